// File: rtl/button_pkg.sv
// button_pkg: shared FSM state type and default parameters for the button conditioner.
package button_pkg;
  typedef enum logic [1:0] {STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO} btn_state_t;
  localparam int DEF_N_CH = 2;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_DEBOUNCE_CYCLES = 50000;
  localparam int DEF_REPEAT_CYCLES = 0;
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, debounce FSM and auto-repeat counter for one button.
module button_channel
  import button_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic level,
  output logic press,
  output logic rel,
  output logic rpt
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RW = REPEAT_CYCLES > 1 ? $clog2(REPEAT_CYCLES) : 1;
  // The entry edge into WAIT counts as the first differing edge, hence the -2.
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES > 1 ? DEBOUNCE_CYCLES - 2 : 0);
  localparam logic [RW-1:0] RLAST = RW'(REPEAT_CYCLES > 0 ? REPEAT_CYCLES - 1 : 0);
  localparam bit DIRECT = DEBOUNCE_CYCLES == 1;
  localparam bit REP_EN = REPEAT_CYCLES != 0;
  logic [SYNC_STAGES-1:0] sync_q;
  logic sync;
  btn_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rcnt_q, rcnt_d;
  logic press_d, rel_d, rpt_d;
  assign sync = sync_q[SYNC_STAGES-1];
  assign level = (state_q == STABLE_HI) || (state_q == WAIT_LO);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      state_q <= STABLE_LO;
      cnt_q <= '0;
      rcnt_q <= '0;
      press <= 1'b0;
      rel <= 1'b0;
      rpt <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn};
      state_q <= state_d;
      cnt_q <= cnt_d;
      rcnt_q <= rcnt_d;
      press <= press_d;
      rel <= rel_d;
      rpt <= rpt_d;
    end
  end
  // Counters default to clear; they only advance while a change or hold is in progress.
  always_comb begin
    state_d = state_q;
    cnt_d = '0;
    rcnt_d = '0;
    press_d = 1'b0;
    rel_d = 1'b0;
    rpt_d = 1'b0;
    case (state_q)
      STABLE_LO: if (sync) begin
        state_d = DIRECT ? STABLE_HI : WAIT_HI;
        press_d = DIRECT;
      end
      WAIT_HI:
        if (!sync) state_d = STABLE_LO;
        else if (cnt_q >= LAST) begin
          state_d = STABLE_HI;
          press_d = 1'b1;
        end else cnt_d = cnt_q + CW'(cnt_q != '1);
      STABLE_HI:
        if (!sync) begin
          state_d = DIRECT ? STABLE_LO : WAIT_LO;
          rel_d = DIRECT;
        end else if (REP_EN) begin
          rpt_d = rcnt_q == RLAST;
          rcnt_d = rpt_d ? '0 : rcnt_q + 1'b1;
        end
      WAIT_LO:
        if (sync) state_d = STABLE_HI;
        else if (cnt_q >= LAST) begin
          state_d = STABLE_LO;
          rel_d = 1'b1;
        end else cnt_d = cnt_q + CW'(cnt_q != '1);
    endcase
    rpt_d = rpt_d | (press_d & REP_EN);
  end
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: N_CH independent debounced buttons with press/release/repeat pulses.
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_press,
  output logic [N_CH-1:0] btn_release,
  output logic [N_CH-1:0] btn_repeat
);
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    button_channel #(
      .SYNC_STAGES(SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk(clk),
      .rst_n(rst_n),
      .btn(btn_in[i]),
      .level(btn_level[i]),
      .press(btn_press[i]),
      .rel(btn_release[i]),
      .rpt(btn_repeat[i])
    );
  end
endmodule
